// File: rtl/seq_shift_unit.sv
// -----------------------------------------------------------------------------
// seq_shift_unit
//
// Multi-cycle shift/rotate register. A command is accepted on a rising edge
// with start=1 while the unit is IDLE or DONE. LOAD and hold complete
// immediately. Shift commands move q by at most STEP bits per cycle until the
// requested amount has been applied. DONE always lasts exactly one cycle, and
// the unit can take a new command during that cycle.
//
// Parameters
//   WIDTH   data width (power of two, >= 8)
//   STEP    maximum bits shifted per clock (power of two, 1..WIDTH)
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    command request
//   op       opcode: 000 hold, 001 SLL, 011 SRL, 010 SRA, 100 ROL,
//            101 ROR, 111 LOAD, 110 reserved (hold)
//   shamt    shift amount, log2(WIDTH) bits
//   data_in  LOAD value
//   q        register contents
//   busy     high while a shift is in progress
//   done     one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic                     done
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so that STEP == WIDTH is representable in the step compare.
  localparam int CW  = SHW + 1;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [SHW-1:0]   r_rem;
  logic [SHW-1:0]   w_rem_next;
  logic [2:0]       r_op;
  logic [2:0]       w_op_next;

  logic             w_accept;
  logic             w_is_shift;
  logic [CW-1:0]    w_rem_ext;
  logic [CW-1:0]    w_k;
  logic [WIDTH-1:0]   w_step_res;
  logic [2*WIDTH-1:0] w_rol_full;
  logic [2*WIDTH-1:0] w_ror_full;

  // Commands are taken in IDLE and DONE; BUSY silently drops start.
  assign w_accept = start && (r_state != S_BUSY);

  always_comb begin
    w_is_shift = 1'b0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: w_is_shift = 1'b1;
      default:                                w_is_shift = 1'b0;
    endcase
  end

  // Bits moved this cycle: min(STEP, remaining).
  assign w_rem_ext = {1'b0, r_rem};
  assign w_k       = (w_rem_ext > CW'(STEP)) ? CW'(STEP) : w_rem_ext;

  // Rotations via a doubled word: the half that survives the shift already
  // holds the wrapped-around bits.
  assign w_rol_full = {r_q, r_q} << w_k;
  assign w_ror_full = {r_q, r_q} >> w_k;

  always_comb begin
    w_step_res = r_q;
    case (r_op)
      OP_SLL:  w_step_res = r_q << w_k;
      OP_SRL:  w_step_res = r_q >> w_k;
      // Sign bit is taken from q as it stands at this step.
      OP_SRA:  w_step_res = WIDTH'($signed(r_q) >>> w_k);
      OP_ROL:  w_step_res = w_rol_full[2*WIDTH-1:WIDTH];
      OP_ROR:  w_step_res = w_ror_full[WIDTH-1:0];
      default: w_step_res = r_q;
    endcase
  end

  // Next-state / datapath logic
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_rem_next   = r_rem;
    w_op_next    = r_op;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_next = S_IDLE;
        if (w_accept) begin
          w_state_next = S_DONE;
          if (op == OP_LOAD) begin
            w_q_next = data_in;
          end else if (w_is_shift) begin
            // q is left alone on the acceptance edge; work starts in BUSY.
            w_op_next  = op;
            w_rem_next = shamt;
            if (shamt != '0) begin
              w_state_next = S_BUSY;
            end
          end
        end
      end
      S_BUSY: begin
        w_q_next   = w_step_res;
        w_rem_next = r_rem - w_k[SHW-1:0];
        if (w_rem_next == '0) begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_op    <= OP_HOLD;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_rem   <= w_rem_next;
      r_op    <= w_op_next;
    end
  end

  assign q    = r_q;
  assign busy = (r_state == S_BUSY);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_unit
//
// Directed bench for seq_shift_unit. Two instances share clock and reset:
// unit A with STEP=1 and unit B with STEP=4, both WIDTH=32. Expected values
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_seq_shift_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_start = 1'b0;
  logic [2:0]  a_op    = 3'b000;
  logic [4:0]  a_shamt = 5'd0;
  logic [31:0] a_data  = 32'h0;
  logic [31:0] a_q;
  logic        a_busy;
  logic        a_done;

  logic        b_start = 1'b0;
  logic [2:0]  b_op    = 3'b000;
  logic [4:0]  b_shamt = 5'd0;
  logic [31:0] b_data  = 32'h0;
  logic [31:0] b_q;
  logic        b_busy;
  logic        b_done;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] SLL  = 3'b001;
  localparam logic [2:0] SRA  = 3'b010;
  localparam logic [2:0] SRL  = 3'b011;
  localparam logic [2:0] ROL  = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] RSVD = 3'b110;
  localparam logic [2:0] LOAD = 3'b111;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(32), .STEP(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .op(a_op), .shamt(a_shamt),
    .data_in(a_data), .q(a_q), .busy(a_busy), .done(a_done)
  );

  seq_shift_unit #(.WIDTH(32), .STEP(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .op(b_op), .shamt(b_shamt),
    .data_in(b_data), .q(b_q), .busy(b_busy), .done(b_done)
  );

  function automatic logic [31:0] get_q(input int sel);
    return (sel == 0) ? a_q : b_q;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? a_busy : b_busy;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? a_done : b_done;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [2:0] o,
                       input logic [4:0] sh, input logic [31:0] d);
    if (sel == 0) begin
      a_start = st; a_op = o; a_shamt = sh; a_data = d;
    end else begin
      b_start = st; b_op = o; b_shamt = sh; b_data = d;
    end
  endtask

  // Called at posedge+1. Issues a command, counts BUSY cycles (bounded), and
  // checks the DONE cycle. Inputs are scrambled after acceptance; with noisy=1
  // a LOAD of all ones is also requested during every BUSY cycle.
  task automatic run(input int sel, input string tag, input logic [2:0] o,
                     input logic [4:0] sh, input logic [31:0] d,
                     input int exp_busy, input logic [31:0] exp_q, input bit noisy);
    int n;
    n = 0;
    drive(sel, 1'b1, o, sh, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 3'b110, 5'd31, 32'hDEAD_BEEF);
    while (get_busy(sel) && n < 100) begin
      n++;
      if (noisy) drive(sel, 1'b1, LOAD, 5'd0, 32'hFFFF_FFFF);
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, HOLD, 5'd0, 32'h0);
    chk({tag, " busy_cycles"}, 32'(n), 32'(exp_busy));
    chk({tag, " done"}, 32'(get_done(sel)), 32'd1);
    chk({tag, " q"}, get_q(sel), exp_q);
  endtask

  // One cycle after DONE with no start: back to IDLE, q stable.
  task automatic idle(input int sel, input string tag, input logic [31:0] exp_q);
    @(posedge clk); #1;
    chk({tag, " idle_done"}, 32'(get_done(sel)), 32'd0);
    chk({tag, " idle_busy"}, 32'(get_busy(sel)), 32'd0);
    chk({tag, " idle_q"}, get_q(sel), exp_q);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst a_q", a_q, 32'h0);
    chk("rst a_busy", 32'(a_busy), 32'd0);
    chk("rst a_done", 32'(a_done), 32'd0);
    chk("rst b_q", b_q, 32'h0);
    chk("rst b_busy", 32'(b_busy), 32'd0);
    chk("rst b_done", 32'(b_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // STEP=1 left shifts
    run(0, "A load1", LOAD, 5'd0, 32'h0000_0001, 0, 32'h0000_0001, 0);
    idle(0, "A load1", 32'h0000_0001);
    run(0, "A sll1", SLL, 5'd1, 32'h0, 1, 32'h0000_0002, 0);
    idle(0, "A sll1", 32'h0000_0002);
    run(0, "A sll6", SLL, 5'd6, 32'h0, 6, 32'h0000_0080, 0);
    idle(0, "A sll6", 32'h0000_0080);
    run(0, "A sll24", SLL, 5'd24, 32'h0, 24, 32'h8000_0000, 0);
    idle(0, "A sll24", 32'h8000_0000);

    // STEP=1 logical right shifts
    run(0, "A srl1", SRL, 5'd1, 32'h0, 1, 32'h4000_0000, 0);
    run(0, "A srl6", SRL, 5'd6, 32'h0, 6, 32'h0100_0000, 0);
    run(0, "A srl24", SRL, 5'd24, 32'h0, 24, 32'h0000_0001, 0);
    idle(0, "A srl24", 32'h0000_0001);

    // STEP=1 arithmetic right shift
    run(0, "A load80", LOAD, 5'd0, 32'h8000_0000, 0, 32'h8000_0000, 0);
    run(0, "A sra4", SRA, 5'd4, 32'h0, 4, 32'hF800_0000, 0);
    idle(0, "A sra4", 32'hF800_0000);

    // Zero-length shift and hold/reserved opcodes
    run(0, "A sll0", SLL, 5'd0, 32'h1234_5678, 0, 32'hF800_0000, 0);
    idle(0, "A sll0", 32'hF800_0000);
    run(0, "A rsvd", RSVD, 5'd7, 32'h1234_5678, 0, 32'hF800_0000, 0);
    run(0, "A hold", HOLD, 5'd7, 32'h1234_5678, 0, 32'hF800_0000, 0);
    idle(0, "A hold", 32'hF800_0000);

    // start during BUSY is ignored
    run(0, "A load3", LOAD, 5'd0, 32'h0000_0003, 0, 32'h0000_0003, 0);
    run(0, "A noisy sll4", SLL, 5'd4, 32'h0, 4, 32'h0000_0030, 1);
    idle(0, "A noisy sll4", 32'h0000_0030);

    // Back-to-back: second command issued during DONE, no IDLE in between
    run(0, "A b2b load", LOAD, 5'd0, 32'h0000_0001, 0, 32'h0000_0001, 0);
    run(0, "A b2b sll2", SLL, 5'd2, 32'h0, 2, 32'h0000_0004, 0);
    run(0, "A b2b sll3", SLL, 5'd3, 32'h0, 3, 32'h0000_0020, 0);
    run(0, "A b2b ror1", ROR, 5'd1, 32'h0, 1, 32'h0000_0010, 0);
    idle(0, "A b2b", 32'h0000_0010);

    // STEP=4 rotates and multi-step shifts
    run(1, "B loadff0", LOAD, 5'd0, 32'h0000_0FF0, 0, 32'h0000_0FF0, 0);
    run(1, "B ror8", ROR, 5'd8, 32'h0, 2, 32'hF000_000F, 0);
    idle(1, "B ror8", 32'hF000_000F);
    run(1, "B rol8", ROL, 5'd8, 32'h0, 2, 32'h0000_0FF0, 0);
    run(1, "B load1", LOAD, 5'd0, 32'h0000_0001, 0, 32'h0000_0001, 0);
    run(1, "B sll24", SLL, 5'd24, 32'h0, 6, 32'h0100_0000, 0);
    run(1, "B load80", LOAD, 5'd0, 32'h8000_0000, 0, 32'h8000_0000, 0);
    run(1, "B sra5", SRA, 5'd5, 32'h0, 2, 32'hFC00_0000, 0);
    run(1, "B rol31", ROL, 5'd31, 32'h0, 8, 32'h7E00_0000, 0);
    idle(1, "B rol31", 32'h7E00_0000);

    // Reset during BUSY: immediate abort, no done afterwards
    run(0, "A pre-rst load", LOAD, 5'd0, 32'h0000_0001, 0, 32'h0000_0001, 0);
    drive(0, 1'b1, SLL, 5'd24, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, HOLD, 5'd0, 32'h0);
    chk("A midrst busy_before", 32'(a_busy), 32'd1);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("A midrst q_async", a_q, 32'h0);
    chk("A midrst busy_async", 32'(a_busy), 32'd0);
    chk("A midrst done_async", 32'(a_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("A midrst done_held", 32'(a_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("A postrst done", 32'(a_done), 32'd0);
    chk("A postrst busy", 32'(a_busy), 32'd0);
    run(0, "A postrst load5", LOAD, 5'd0, 32'h0000_0005, 0, 32'h0000_0005, 0);
    idle(0, "A postrst", 32'h0000_0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a power of two and at least 8.
REQ-002 Parameter STEP, default 1, maximum bits shifted per clock; SHALL be a power of two with 1 <= STEP <= WIDTH.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1, reset; SHALL be asynchronous and active-high.
REQ-005 Port start, input, 1, command request.
REQ-006 Port op, input, 3, opcode: 000 hold, 001 SLL, 011 SRL, 010 SRA, 100 ROL, 101 ROR, 111 LOAD, 110 reserved (treated as hold).
REQ-007 Port shamt, input, log2(WIDTH), shift amount.
REQ-008 Port data_in, input, WIDTH, load value.
REQ-009 Port q, output, WIDTH, register contents.
REQ-010 Port busy, output, 1, high while a shift is in progress.
REQ-011 Port done, output, 1, one-cycle completion pulse.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; busy SHALL be 1 only in BUSY; done SHALL be 1 only in DONE.
REQ-013 A command SHALL be accepted on a rising edge with start=1 while in IDLE or DONE; start in BUSY SHALL be ignored and not queued.
REQ-014 LOAD accepted: q <= data_in at that edge; next state DONE.
REQ-015 Hold or reserved accepted: q unchanged; next state DONE.
REQ-016 Shift accepted: latch op and shamt into internal registers; remaining count <= shamt; q not modified at that edge; next state BUSY if shamt > 0, else DONE.
REQ-017 Shifts SHALL act on the current q, not on data_in.
REQ-018 Each BUSY cycle: shift q by k = min(STEP, remaining); remaining -= k; on remaining reaching 0, next state DONE.
REQ-019 Busy duration SHALL be ceil(shamt/STEP) cycles; done SHALL assert the cycle after the last BUSY cycle.
REQ-020 SLL: zero fill at LSB. SRL: zero fill at MSB. SRA: fill with q[WIDTH-1] as held at each step. ROL/ROR: bits shifted out re-enter at the opposite end.
REQ-021 Final q SHALL equal the single-step result of the same op by shamt for every STEP value.
REQ-022 DONE SHALL last exactly one cycle; next state is IDLE, unless start=1 in that cycle, in which case the new command is accepted (back-to-back).
REQ-023 inputs op, shamt and data_in SHALL be sampled only at acceptance; later changes SHALL not affect an operation in progress.
REQ-024 q SHALL be stable in IDLE and DONE.

Reset
REQ-025 While rst=1: q=0, state IDLE, busy=0, done=0, remaining=0, latched op=hold, independent of clk.
REQ-026 Asserting rst during BUSY SHALL abort the operation at once; no done pulse SHALL follow.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-028 STEP=1: LOAD 0x00000001, then SLL 1, SLL 6, SLL 24 -> q=0x00000002, 0x00000080, 0x80000000; busy lengths 1, 6, 24 cycles.
REQ-029 STEP=1: from 0x80000000, SRL 1, SRL 6, SRL 24 -> 0x40000000, 0x01000000, 0x00000001; separately SRA 4 on 0x80000000 -> 0xF8000000.
REQ-030 STEP=4: LOAD 0x00000FF0, ROR 8 -> 0xF000000F after 2 busy cycles; then ROL 8 -> 0x00000FF0; SLL 24 from 0x1 -> 6 busy cycles.
REQ-031 shamt=0 SLL and hold opcode 110 -> no busy cycle, done next cycle, q unchanged; start pulses during BUSY -> ignored, result matches single command.
REQ-032 rst asserted mid-SLL 24 (cycle 10) -> q=0, busy=0 asynchronously, no done; back-to-back start during DONE -> accepted with no IDLE cycle.
